// File: rtl/rtc_pkg.sv
// Shared constants for the IEEE 1588 real-time clock core.
//   RTC_NS_W / RTC_NSF_W : integer ns and sub-ns fraction widths of the time-of-day counter
//   RTC_SEC_W            : seconds counter width
//   RTC_PER_NS_W / _F_W  : integer and fraction widths of the 8.32 period
//   RTC_DS_W             : period fraction bits folded in by the delta-sigma accumulator
//   RTC_MODULO_DEFAULT   : nominal ns rollover (1e9 ns in 30.8 format)
package rtc_pkg;

  localparam int unsigned RTC_NS_W     = 30;
  localparam int unsigned RTC_NSF_W    = 8;
  localparam int unsigned RTC_SEC_W    = 48;
  localparam int unsigned RTC_PER_NS_W = 8;
  localparam int unsigned RTC_PER_F_W  = 32;
  localparam int unsigned RTC_DS_W     = 24;

  // Derived widths.
  localparam int unsigned RTC_TNS_W = RTC_NS_W + RTC_NSF_W;         // 38, 30.8 time of day
  localparam int unsigned RTC_PER_W = RTC_PER_NS_W + RTC_PER_F_W;   // 40, 8.32 period
  localparam int unsigned RTC_INC_W = RTC_PER_W - RTC_DS_W;         // 16, 8.8 increment

  localparam logic [RTC_TNS_W-1:0] RTC_MODULO_DEFAULT = 38'd256_000000000;

endpackage

// File: rtl/rtc_delta_sigma.sv
// First-order delta-sigma accumulator for the period fraction bits that the 8.8 time counter
// cannot represent. Each cycle frac is added to the accumulator; the overflow is the carry that
// the time counter adds as one extra 1/256 ns, so the long-term rate is exact.
//   clk   in   RTC clock
//   rst   in   asynchronous active-high reset
//   frac  in   low RTC_DS_W bits of the effective period
//   carry out  overflow of acc + frac this cycle (combinational)
module rtc_delta_sigma
  import rtc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [RTC_DS_W-1:0] frac,
  output logic                carry
);

  logic [RTC_DS_W-1:0] ds_acc_q;
  logic [RTC_DS_W:0]   ds_sum;

  assign ds_sum = {1'b0, ds_acc_q} + {1'b0, frac};
  assign carry  = ds_sum[RTC_DS_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_acc_q <= '0;
    end else begin
      ds_acc_q <= ds_sum[RTC_DS_W-1:0];
    end
  end

endmodule

// File: rtl/rtc_timer_core.sv
// Free-running IEEE 1588 RTC: 48-bit seconds plus 30.8 nanoseconds, advanced every cycle by a
// programmable 8.32 ns period, with optional timed phase adjustment.
// Build option: define RTC_DELTA_SIGMA_EN to fold the low 24 period fraction bits in through a
// delta-sigma accumulator; otherwise those bits are truncated.
//   clk, rst          RTC clock, asynchronous active-high reset
//   time_ld           load time of day (time_reg_ns_in / time_reg_sec_in) this cycle
//   period_ld         load period_in (8.32 ns)
//   time_acc_modulo   ns rollover value, 30.8 format, quasi-static
//   adj_ld            start timed adjustment: period_adj added for adj_ld_data increments
//   time_reg_ns/_sec  registered current time of day
module rtc_timer_core
  import rtc_pkg::*;
(
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 time_ld,
  input  logic [RTC_TNS_W-1:0] time_reg_ns_in,
  input  logic [RTC_SEC_W-1:0] time_reg_sec_in,
  input  logic                 period_ld,
  input  logic [RTC_PER_W-1:0] period_in,
  input  logic [RTC_TNS_W-1:0] time_acc_modulo,
  input  logic                 adj_ld,
  input  logic [31:0]          adj_ld_data,
  input  logic [RTC_PER_W-1:0] period_adj,
  output logic [RTC_TNS_W-1:0] time_reg_ns,
  output logic [RTC_SEC_W-1:0] time_reg_sec
);

  logic [RTC_PER_W-1:0] period_q, period_d;
  logic [RTC_PER_W-1:0] adj_period_q, adj_period_d;
  logic [31:0]          adj_cnt_q, adj_cnt_d;
  logic [RTC_TNS_W-1:0] ns_q, ns_d;
  logic [RTC_SEC_W-1:0] sec_q, sec_d;

  logic                 adj_active;
  logic [RTC_PER_W-1:0] time_adj_08n_32f;
  logic                 carry;
  logic [RTC_INC_W-1:0] inc;
  logic [RTC_TNS_W:0]   ns_sum;
  logic [RTC_TNS_W:0]   ns_sub;
  logic                 ns_wrap;

  assign adj_active       = (adj_cnt_q != 32'd0);
  assign time_adj_08n_32f = period_q + (adj_active ? adj_period_q : '0);

`ifdef RTC_DELTA_SIGMA_EN
  rtc_delta_sigma u_delta_sigma (
    .clk   (clk),
    .rst   (rst),
    .frac  (time_adj_08n_32f[RTC_DS_W-1:0]),
    .carry (carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^time_adj_08n_32f[RTC_DS_W-1:0];
  assign carry       = 1'b0;
`endif

  assign inc = time_adj_08n_32f[RTC_PER_W-1:RTC_DS_W] + {{(RTC_INC_W-1){1'b0}}, carry};

  // One spare bit so ns + inc cannot overflow before the rollover compare.
  assign ns_sum  = {1'b0, ns_q} + {{(RTC_TNS_W+1-RTC_INC_W){1'b0}}, inc};
  assign ns_sub  = ns_sum - {1'b0, time_acc_modulo};
  assign ns_wrap = (ns_sum >= {1'b0, time_acc_modulo});

  always_comb begin
    period_d = period_ld ? period_in : period_q;
  end

  // A new adj_ld reloads any adjustment in progress instead of decrementing it.
  always_comb begin
    adj_period_d = adj_period_q;
    adj_cnt_d    = adj_cnt_q;
    if (adj_ld) begin
      adj_period_d = period_adj;
      adj_cnt_d    = adj_ld_data;
    end else if (adj_active) begin
      adj_cnt_d = adj_cnt_q - 32'd1;
    end
  end

  always_comb begin
    ns_d  = ns_q;
    sec_d = sec_q;
    if (time_ld) begin
      ns_d  = time_reg_ns_in;
      sec_d = time_reg_sec_in;
    end else if (ns_wrap) begin
      ns_d  = ns_sub[RTC_TNS_W-1:0];
      sec_d = sec_q + {{(RTC_SEC_W-1){1'b0}}, 1'b1};
    end else begin
      ns_d = ns_sum[RTC_TNS_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q     <= '0;
      adj_period_q <= '0;
      adj_cnt_q    <= '0;
      ns_q         <= '0;
      sec_q        <= '0;
    end else begin
      period_q     <= period_d;
      adj_period_q <= adj_period_d;
      adj_cnt_q    <= adj_cnt_d;
      ns_q         <= ns_d;
      sec_q        <= sec_d;
    end
  end

  assign time_reg_ns  = ns_q;
  assign time_reg_sec = sec_q;

endmodule

// File: tb/tb_rtc_timer_core.sv
// Directed self-checking bench for rtc_timer_core. Expected values are hand-computed; the
// delta-sigma carries are only expected when RTC_DELTA_SIGMA_EN is defined.
module tb_rtc_timer_core;
  import rtc_pkg::*;

`ifdef RTC_DELTA_SIGMA_EN
  localparam bit DsEn = 1'b1;
`else
  localparam bit DsEn = 1'b0;
`endif

  logic        rst;
  logic        clk;
  logic        time_ld;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic        period_ld;
  logic [39:0] period_in;
  logic [37:0] time_acc_modulo;
  logic        adj_ld;
  logic [31:0] adj_ld_data;
  logic [39:0] period_adj;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [63:0] exp_ns;

  rtc_timer_core dut (
    .rst             (rst),
    .clk             (clk),
    .time_ld         (time_ld),
    .time_reg_ns_in  (time_reg_ns_in),
    .time_reg_sec_in (time_reg_sec_in),
    .period_ld       (period_ld),
    .period_in       (period_in),
    .time_acc_modulo (time_acc_modulo),
    .adj_ld          (adj_ld),
    .adj_ld_data     (adj_ld_data),
    .period_adj      (period_adj),
    .time_reg_ns     (time_reg_ns),
    .time_reg_sec    (time_reg_sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    time_ld         = 1'b0;
    time_reg_ns_in  = '0;
    time_reg_sec_in = '0;
    period_ld       = 1'b0;
    period_in       = '0;
    time_acc_modulo = RTC_MODULO_DEFAULT;
    adj_ld          = 1'b0;
    adj_ld_data     = '0;
    period_adj      = '0;

    // Reset state, and no advance with period 0.
    step();
    step();
    rst = 1'b0;
    check("reset_ns", 64'(time_reg_ns), 64'd0);
    check("reset_sec", 64'(time_reg_sec), 64'd0);
    step();
    step();
    check("idle_ns", 64'(time_reg_ns), 64'd0);
    check("idle_sec", 64'(time_reg_sec), 64'd0);

    // Period 8.0 ns: load edge still uses the old period, then +0x800 per cycle.
    period_ld = 1'b1;
    period_in = 40'h08_0000_0000;
    step();
    period_ld = 1'b0;
    check("period_ld_edge_ns", 64'(time_reg_ns), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("period8_ns", 64'(time_reg_ns), 64'h800 * 64'(k));
    end

    // Time load and ns rollover into seconds.
    time_ld         = 1'b1;
    time_reg_ns_in  = 38'(64'd999999990 * 64'd256);
    time_reg_sec_in = 48'd10;
    step();
    time_ld = 1'b0;
    check("tload_ns", 64'(time_reg_ns), 64'd999999990 * 64'd256);
    check("tload_sec", 64'(time_reg_sec), 64'd10);
    step();
    check("tinc_ns", 64'(time_reg_ns), 64'd999999998 * 64'd256);
    check("tinc_sec", 64'(time_reg_sec), 64'd10);
    step();
    check("roll_ns", 64'(time_reg_ns), 64'd6 * 64'd256);
    check("roll_sec", 64'(time_reg_sec), 64'd11);

    // Asynchronous reset mid-operation clears before any edge.
    rst = 1'b1;
    #1;
    check("async_rst_ns", 64'(time_reg_ns), 64'd0);
    check("async_rst_sec", 64'(time_reg_sec), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ns", 64'(time_reg_ns), 64'd0);

    // Fractional period 8.0x10 + 0x200000/2^32: carry every eighth increment.
    period_ld = 1'b1;
    period_in = 40'h08_1020_0000;
    step();
    period_ld = 1'b0;
    check("frac_ld_edge_ns", 64'(time_reg_ns), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("frac_ns", 64'(time_reg_ns), 64'h810 * 64'(k) + ((k == 8 && DsEn) ? 64'd1 : 64'd0));
    end
    check("frac_8cyc_ns", 64'(time_reg_ns), DsEn ? 64'h4081 : 64'h4080);

    // Timed adjustment: period 8.0 + 2.0x20 + 0x800000/2^32 for 10 increments.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    period_ld = 1'b1;
    period_in = 40'h08_0000_0000;
    step();
    period_ld   = 1'b0;
    adj_ld      = 1'b1;
    period_adj  = 40'h02_2080_0000;
    adj_ld_data = 32'd10;
    step();
    adj_ld = 1'b0;
    exp_ns = 64'h800;
    check("adj_ld_edge_ns", 64'(time_reg_ns), exp_ns);
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_ns = exp_ns + 64'hA20 + ((k % 2 == 0 && DsEn) ? 64'd1 : 64'd0);
      check("adj_active_ns", 64'(time_reg_ns), exp_ns);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      exp_ns = exp_ns + 64'h800;
      check("adj_done_ns", 64'(time_reg_ns), exp_ns);
    end

    // K = 0 adds nothing.
    adj_ld      = 1'b1;
    adj_ld_data = 32'd0;
    step();
    adj_ld = 1'b0;
    exp_ns = exp_ns + 64'h800;
    check("adj_k0_edge_ns", 64'(time_reg_ns), exp_ns);
    step();
    exp_ns = exp_ns + 64'h800;
    check("adj_k0_ns", 64'(time_reg_ns), exp_ns);

    // Seconds wrap 2^48-1 -> 0.
    time_ld         = 1'b1;
    time_reg_ns_in  = 38'(64'd999999996 * 64'd256);
    time_reg_sec_in = 48'hFFFF_FFFF_FFFF;
    step();
    time_ld = 1'b0;
    check("secmax_sec", 64'(time_reg_sec), 64'hFFFF_FFFF_FFFF);
    step();
    check("secwrap_ns", 64'(time_reg_ns), 64'd4 * 64'd256);
    check("secwrap_sec", 64'(time_reg_sec), 64'd0);

    // Loaded ns above the modulo rolls over once.
    time_ld         = 1'b1;
    time_reg_ns_in  = 38'h3F_FFFF_FFFF;
    time_reg_sec_in = 48'd5;
    step();
    time_ld = 1'b0;
    check("overmod_ld_ns", 64'(time_reg_ns), 64'h3F_FFFF_FFFF);
    step();
    check("overmod_ns", 64'(time_reg_ns), 64'h04_6536_07FF);
    check("overmod_sec", 64'(time_reg_sec), 64'd6);

    // Simultaneous time, period and adjustment loads.
    time_ld         = 1'b1;
    time_reg_ns_in  = 38'd0;
    time_reg_sec_in = 48'd1;
    period_ld       = 1'b1;
    period_in       = 40'h04_0000_0000;
    adj_ld          = 1'b1;
    period_adj      = 40'h01_0000_0000;
    adj_ld_data     = 32'd1;
    step();
    time_ld   = 1'b0;
    period_ld = 1'b0;
    adj_ld    = 1'b0;
    check("simul_ld_ns", 64'(time_reg_ns), 64'd0);
    check("simul_ld_sec", 64'(time_reg_sec), 64'd1);
    step();
    check("simul_adj_ns", 64'(time_reg_ns), 64'h500);
    step();
    check("simul_after_ns", 64'(time_reg_ns), 64'h900);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
